// File: rtl/uart_loader_pkg.sv
// Shared types and ASCII constants for the UART hex loader.
package uart_loader_pkg;

   localparam int unsigned DEF_ADDR_W = 4;
   localparam int unsigned DEF_DEPTH  = 16;

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_PROC = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [7:0] CH_SP    = 8'h20;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_COMMA = 8'h2C;
   localparam logic [7:0] CH_TERM  = 8'h2E;

endpackage

// File: rtl/uart_hex_loader_if.sv
// UART rx/tx handshakes, instruction-memory write port and load status.
interface uart_hex_loader_if #(
   parameter int unsigned ADDR_W = 4
);
   logic [7:0]        rx_data;
   logic              rx_rdy;
   logic              rx_clr;
   logic              tx_busy;
   logic [7:0]        tx_data;
   logic              tx_wr;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   word_count;
   logic              load_done;
   logic              err_char;
   logic              err_ovf;

   modport master (
      input  rx_data, rx_rdy, tx_busy,
      output rx_clr, tx_data, tx_wr, imem_we, imem_waddr, imem_wdata,
             word_count, load_done, err_char, err_ovf
   );

   modport slave (
      output rx_data, rx_rdy, tx_busy,
      input  rx_clr, tx_data, tx_wr, imem_we, imem_waddr, imem_wdata,
             word_count, load_done, err_char, err_ovf
   );
endinterface

// File: rtl/uart_hex_loader_decoder.sv
// Combinational ASCII classifier: hex digit value, separator, terminator.
module ascii_hex_decoder
   import uart_loader_pkg::*;
(
   input  logic [7:0] data,
   output logic       is_hex,
   output logic [3:0] nibble,
   output logic       is_sep,
   output logic       is_term
);

   always_comb begin
      is_hex = 1'b0;
      nibble = 4'h0;
      if (data >= 8'h30 && data <= 8'h39) begin
         is_hex = 1'b1;
         nibble = 4'(data - 8'h30);
      end else if (data >= 8'h41 && data <= 8'h46) begin
         is_hex = 1'b1;
         nibble = 4'(data - 8'h37);
      end else if (data >= 8'h61 && data <= 8'h66) begin
         is_hex = 1'b1;
         nibble = 4'(data - 8'h57);
      end
   end

   assign is_sep  = (data == CH_SP) || (data == CH_CR) ||
                    (data == CH_LF) || (data == CH_COMMA);
   assign is_term = (data == CH_TERM);

endmodule

// File: rtl/uart_hex_loader.sv
// Parses ASCII-hex bytes from the UART into 32-bit words written to instruction memory.
module uart_hex_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   uart_hex_loader_if.master bus
);

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [7:0]        byte_q, byte_d;
   logic [2:0]        nib_q, nib_d;
   logic [31:0]       sh_q, sh_d;
   logic [ADDR_W:0]   widx_q, widx_d;

   logic              rx_clr_q, rx_clr_d;
   logic              tx_wr_q, tx_wr_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              err_char_q, err_char_d;
   logic              err_ovf_q, err_ovf_d;

   logic              is_hex, is_sep, is_term;
   logic [3:0]        nibble;
   logic [31:0]       sh_shift;

   ascii_hex_decoder u_dec (
      .data    (byte_q),
      .is_hex  (is_hex),
      .nibble  (nibble),
      .is_sep  (is_sep),
      .is_term (is_term)
   );

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_WAIT;
         byte_q     <= '0;
         nib_q      <= '0;
         sh_q       <= '0;
         widx_q     <= '0;
         rx_clr_q   <= 1'b0;
         tx_wr_q    <= 1'b0;
         tx_data_q  <= '0;
         imem_we_q  <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         err_char_q <= 1'b0;
         err_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_q     <= byte_d;
         nib_q      <= nib_d;
         sh_q       <= sh_d;
         widx_q     <= widx_d;
         rx_clr_q   <= rx_clr_d;
         tx_wr_q    <= tx_wr_d;
         tx_data_q  <= tx_data_d;
         imem_we_q  <= imem_we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         done_q     <= done_d;
         err_char_q <= err_char_d;
         err_ovf_q  <= err_ovf_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d    = state_q;
      byte_d     = byte_q;
      nib_d      = nib_q;
      sh_d       = sh_q;
      widx_d     = widx_q;
      rx_clr_d   = 1'b0;
      tx_wr_d    = 1'b0;
      tx_data_d  = tx_data_q;
      imem_we_d  = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      done_d     = done_q;
      err_char_d = err_char_q;
      err_ovf_d  = err_ovf_q;
      sh_shift   = {sh_q[27:0], nibble};

      case (state_q)
         S_WAIT: begin
            if (bus.rx_rdy && !bus.tx_busy) begin
               byte_d   = bus.rx_data;
               rx_clr_d = 1'b1;
               state_d  = S_PROC;
            end
         end

         S_PROC: begin
            state_d = S_HOLD;
            // Once loading is done bytes are only drained, never parsed or echoed
            if (!done_q) begin
               tx_wr_d   = 1'b1;
               tx_data_d = byte_q;
               if (is_hex) begin
                  sh_d = sh_shift;
                  if (nib_q == 3'd7) begin
                     nib_d = '0;
                     if (widx_q < DEPTH_W) begin
                        imem_we_d = 1'b1;
                        waddr_d   = widx_q[ADDR_W-1:0];
                        wdata_d   = sh_shift;
                        widx_d    = widx_q + 1'b1;
                     end else begin
                        err_ovf_d = 1'b1;
                     end
                  end else begin
                     nib_d = nib_q + 3'd1;
                  end
               end else if (is_term) begin
                  done_d = 1'b1;
                  if (nib_q != 3'd0) err_char_d = 1'b1;
                  nib_d = '0;
                  sh_d  = '0;
               end else if (is_sep) begin
                  if (nib_q != 3'd0) begin
                     err_char_d = 1'b1;
                     nib_d      = '0;
                     sh_d       = '0;
                  end
               end else begin
                  err_char_d = 1'b1;
                  nib_d      = '0;
                  sh_d       = '0;
               end
            end
         end

         S_HOLD: state_d = S_WAIT;

         default: state_d = S_WAIT;
      endcase
   end

   assign bus.rx_clr     = rx_clr_q;
   assign bus.tx_wr      = tx_wr_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.imem_we    = imem_we_q;
   assign bus.imem_waddr = waddr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.word_count = widx_q;
   assign bus.load_done  = done_q;
   assign bus.err_char   = err_char_q;
   assign bus.err_ovf    = err_ovf_q;

endmodule
